mem_arbiter: RTL and testbench

- Shares one unified memory port between the instruction-fetch requester (IF) and the load/store requester (D) of the multi-cycle rv32i core.
- Accepts at most one outstanding transaction and routes the response back to its owner.
- Sequences the memory handshake (issue, wait, response) and converts unresponsive memory into a fault via a timeout.
- Sits between the fetch/memory-stage logic and the shared memory model.

---
 rtl/mem_arb_pkg.sv | 20 ++
 rtl/mem_arb_pick.sv | 44 ++++
 rtl/mem_arbiter.sv | 139 +++++++++++++
 tb/tb_mem_arbiter.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified-memory arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    DRAIN
  } arb_state_t;

  typedef enum logic {
    OWNER_IF,
    OWNER_D
  } owner_t;

  localparam logic [1:0] WIDTH_BYTE = 2'd0;
  localparam logic [1:0] WIDTH_HALF = 2'd1;
  localparam logic [1:0] WIDTH_WORD = 2'd2;

endpackage

// File: rtl/mem_arb_pick.sv
// Winner select between IF and D requesters.
// MEM_ARB_ROUND_ROBIN_EN adds a last_owner register; otherwise D has fixed priority.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic   clock,
  input  logic   reset,
  input  logic   if_req,
  input  logic   d_req,
  input  logic   upd,
  output logic   pending,
  output owner_t win
);

  assign pending = if_req | d_req;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  owner_t last_owner;

  // On contention the requester not granted last time wins.
  always_comb begin
    win = OWNER_D;
    if (if_req && d_req) begin
      win = (last_owner == OWNER_D) ? OWNER_IF : OWNER_D;
    end else if (if_req) begin
      win = OWNER_IF;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      last_owner <= OWNER_IF;
    end else if (upd) begin
      last_owner <= win;
    end
  end
`else
  logic unused_ok;

  assign win       = d_req ? OWNER_D : OWNER_IF;
  assign unused_ok = ^{clock, reset, upd};
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory port between IF and D with one outstanding transaction and a timeout.
// Contention policy is fixed D priority unless MEM_ARB_ROUND_ROBIN_EN is defined.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned ILEN    = 32,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            if_req,
  input  logic [XLEN-1:0] if_addr,
  output logic            if_gnt,
  output logic            if_rvalid,
  output logic [ILEN-1:0] if_rdata,
  output logic            if_fault,
  input  logic            d_req,
  input  logic            d_we,
  input  logic [XLEN-1:0] d_addr,
  input  logic [1:0]      d_width,
  input  logic [XLEN-1:0] d_wdata,
  output logic            d_gnt,
  output logic            d_rvalid,
  output logic [XLEN-1:0] d_rdata,
  output logic            d_fault,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [1:0]      mem_width,
  output logic [XLEN-1:0] mem_wdata,
  input  logic            mem_ready,
  input  logic            mem_rvalid,
  input  logic [XLEN-1:0] mem_rdata,
  input  logic            mem_fault
);

  localparam int unsigned   CW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  arb_state_t      state;
  owner_t          owner;
  owner_t          win;
  logic            pending;
  logic            grant;
  logic            timeout_hit;
  logic            resp;
  logic [CW-1:0]   cnt;
  logic            cap_we;
  logic [XLEN-1:0] cap_addr;
  logic [1:0]      cap_width;
  logic [XLEN-1:0] cap_wdata;

  mem_arb_pick u_pick (
    .clock   (clock),
    .reset   (reset),
    .if_req  (if_req),
    .d_req   (d_req),
    .upd     (grant),
    .pending (pending),
    .win     (win)
  );

  // Grant is combinational in IDLE and suppressed while reset is held.
  assign grant       = (state == IDLE) && pending && !reset;
  assign timeout_hit = (TIMEOUT != 0) && (state == WAIT) && !mem_rvalid && (cnt == CNT_LAST);
  assign resp        = (state == WAIT) && (mem_rvalid || timeout_hit);

  assign if_gnt    = grant && (win == OWNER_IF);
  assign d_gnt     = grant && (win == OWNER_D);
  assign if_rvalid = resp && (owner == OWNER_IF);
  assign d_rvalid  = resp && (owner == OWNER_D);
  assign if_rdata  = (if_rvalid && mem_rvalid) ? mem_rdata[ILEN-1:0] : '0;
  assign d_rdata   = (d_rvalid && mem_rvalid) ? mem_rdata : '0;
  assign if_fault  = if_rvalid && (timeout_hit || mem_fault);
  assign d_fault   = d_rvalid && (timeout_hit || mem_fault);

  assign mem_req   = (state == ISSUE);
  assign mem_we    = cap_we;
  assign mem_addr  = cap_addr;
  assign mem_width = cap_width;
  assign mem_wdata = cap_wdata;

  // Handshake sequencer with captured request attributes.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      owner     <= OWNER_IF;
      cnt       <= '0;
      cap_we    <= 1'b0;
      cap_addr  <= '0;
      cap_width <= '0;
      cap_wdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant) begin
            owner <= win;
            state <= ISSUE;
            if (win == OWNER_D) begin
              cap_we    <= d_we;
              cap_addr  <= d_addr;
              cap_width <= d_width;
              cap_wdata <= d_wdata;
            end else begin
              cap_we    <= 1'b0;
              cap_addr  <= if_addr;
              cap_width <= WIDTH_WORD;
              cap_wdata <= '0;
            end
          end
        end
        ISSUE: begin
          if (mem_ready) begin
            state <= WAIT;
            cnt   <= '0;
          end
        end
        WAIT: begin
          if (mem_rvalid) begin
            state <= IDLE;
          end else if (timeout_hit) begin
            state <= DRAIN;
          end else if (TIMEOUT != 0) begin
            cnt <= cnt + CW'(1);
          end
        end
        DRAIN: begin
          // The late response after a timeout is swallowed here.
          if (mem_rvalid) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed stimulus pushes expected events,
// a negedge monitor pops and compares grants, memory accepts and responses.
module tb_mem_arbiter;

  localparam int K_IGNT = 0;
  localparam int K_DGNT = 1;
  localparam int K_MEM  = 2;
  localparam int K_IRSP = 3;
  localparam int K_DRSP = 4;

  typedef struct {
    string       name;
    int          kind;
    int          cyc;
    logic [31:0] a;
    logic [31:0] wd;
    logic        we;
    logic [1:0]  w;
    logic        f;
  } ev_t;

  logic        clock = 1'b0;
  logic        reset;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt, if_rvalid, if_fault;
  logic [31:0] if_rdata;
  logic        d_req, d_we;
  logic [31:0] d_addr, d_wdata;
  logic [1:0]  d_width;
  logic        d_gnt, d_rvalid, d_fault;
  logic [31:0] d_rdata;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [1:0]  mem_width;
  logic        mem_ready, mem_rvalid, mem_fault;
  logic [31:0] mem_rdata;

  ev_t sb[$];
  int  cyc = 0;
  int  n_vec = 0;
  int  n_bad = 0;

  mem_arbiter #(.XLEN(32), .ILEN(32), .TIMEOUT(4)) dut (
    .clock(clock), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
    .if_rdata(if_rdata), .if_fault(if_fault),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_width(d_width), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_fault(d_fault),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_width(mem_width),
    .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata), .mem_fault(mem_fault)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc++;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push(input string nm, input int k, input int c, input logic [31:0] a,
                      input logic [31:0] wd, input logic we, input logic [1:0] w, input logic f);
    ev_t e;
    e.name = nm; e.kind = k; e.cyc = c; e.a = a; e.wd = wd; e.we = we; e.w = w; e.f = f;
    sb.push_back(e);
  endtask

  task automatic push_gnt(input bit is_d, input int c);
    push(is_d ? "d_gnt" : "if_gnt", is_d ? K_DGNT : K_IGNT, c, 32'h0, 32'h0, 1'b0, 2'd0, 1'b0);
  endtask

  task automatic push_mem(input int c, input logic [31:0] a, input logic [31:0] wd,
                          input logic we, input logic [1:0] w);
    push("mem_req", K_MEM, c, a, wd, we, w, 1'b0);
  endtask

  task automatic push_rsp(input bit is_d, input int c, input logic [31:0] rd, input logic f);
    push(is_d ? "d_rsp" : "if_rsp", is_d ? K_DRSP : K_IRSP, c, rd, 32'h0, 1'b0, 2'd0, f);
  endtask

  task automatic push_txn(input bit is_d, input int c, input logic [31:0] a, input logic [31:0] wd,
                          input logic we, input logic [1:0] w, input logic [31:0] rd, input logic f);
    push_gnt(is_d, c);
    push_mem(c + 1, a, wd, we, w);
    push_rsp(is_d, c + 2, rd, f);
  endtask

  task automatic observe(input int kind, input logic [31:0] a, input logic [31:0] wd,
                         input logic we, input logic [1:0] w, input logic f);
    ev_t e;
    bit  ok;
    n_vec++;
    if (sb.size() == 0) begin
      n_bad++;
      $display("FAIL unexpected_event: got kind=%0d at cycle %0d, required no event", kind, cyc);
      return;
    end
    e  = sb.pop_front();
    ok = (e.kind == kind) && (e.cyc == cyc);
    if (kind == K_MEM)
      ok = ok && (a == e.a) && (we == e.we) && (w == e.w) && (!e.we || wd == e.wd);
    if (kind == K_IRSP || kind == K_DRSP)
      ok = ok && (a == e.a) && (f == e.f);
    if (!ok) begin
      n_bad++;
      $display("FAIL %s: got kind=%0d cyc=%0d a=%h wd=%h we=%b w=%0d f=%b, required kind=%0d cyc=%0d a=%h wd=%h we=%b w=%0d f=%b",
               e.name, kind, cyc, a, wd, we, w, f, e.kind, e.cyc, e.a, e.wd, e.we, e.w, e.f);
    end
  endtask

  task automatic check_zero(input string nm);
    logic [137:0] v;
    v = {if_gnt, if_rvalid, if_rdata, if_fault, d_gnt, d_rvalid, d_rdata, d_fault,
         mem_req, mem_we, mem_addr, mem_width, mem_wdata};
    n_vec++;
    if (v != '0) begin
      n_bad++;
      $display("FAIL %s: outputs got %h, required all zero", nm, v);
    end
  endtask

  // Monitor: every presented DUT event must match the head of the scoreboard.
  always @(negedge clock) begin
    if (if_gnt)              observe(K_IGNT, 32'h0, 32'h0, 1'b0, 2'd0, 1'b0);
    if (d_gnt)               observe(K_DGNT, 32'h0, 32'h0, 1'b0, 2'd0, 1'b0);
    if (mem_req && mem_ready) observe(K_MEM, mem_addr, mem_wdata, mem_we, mem_width, 1'b0);
    if (if_rvalid)           observe(K_IRSP, if_rdata, 32'h0, 1'b0, 2'd0, if_fault);
    if (d_rvalid)            observe(K_DRSP, d_rdata, 32'h0, 1'b0, 2'd0, d_fault);
  end

  initial begin
    int  c0;
    bit  if_first;
    bit  is_d;
    logic [31:0] rd;

    reset = 1'b1;
    if_req = 1'b0; if_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_width = '0; d_wdata = '0;
    mem_ready = 1'b1; mem_rvalid = 1'b0; mem_rdata = '0; mem_fault = 1'b0;
    repeat (3) tick();
    check_zero("reset_state");
    reset = 1'b0;

    // Reset asserted mid-WAIT; requests under reset must not be granted.
    c0 = cyc;
    if_req = 1'b1; if_addr = 32'h10;
    push_gnt(1'b0, c0);
    push_mem(c0 + 1, 32'h10, 32'h0, 1'b0, 2'd2);
    tick(); if_req = 1'b0;
    tick();
    reset = 1'b1; if_req = 1'b1; d_req = 1'b1; d_addr = 32'h44; mem_rvalid = 1'b1;
    #1 check_zero("reset_mid_wait");
    tick();
    check_zero("reset_held");
    d_req = 1'b0; mem_rvalid = 1'b0; reset = 1'b0;
    c0 = cyc;
    push_txn(1'b0, c0, 32'h10, 32'h0, 1'b0, 2'd2, 32'h11111111, 1'b0);
    tick(); if_req = 1'b0; mem_rdata = 32'h11111111;
    tick(); mem_rvalid = 1'b1;
    tick(); mem_rvalid = 1'b0;

    // Lone IF read.
    c0 = cyc;
    if_req = 1'b1; if_addr = 32'h100;
    push_txn(1'b0, c0, 32'h100, 32'h0, 1'b0, 2'd2, 32'h00500093, 1'b0);
    tick(); if_req = 1'b0;
    tick(); mem_rvalid = 1'b1; mem_rdata = 32'h00500093;
    tick(); mem_rvalid = 1'b0;

    // D load answered with a memory fault.
    c0 = cyc;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h500; d_width = 2'd2;
    push_txn(1'b1, c0, 32'h500, 32'h0, 1'b0, 2'd2, 32'hCAFE0000, 1'b1);
    tick(); d_req = 1'b0;
    tick(); mem_rvalid = 1'b1; mem_fault = 1'b1; mem_rdata = 32'hCAFE0000;
    tick(); mem_rvalid = 1'b0; mem_fault = 1'b0;

    // Contention: D store vs IF read; last grant was D.
`ifdef MEM_ARB_ROUND_ROBIN_EN
    if_first = 1'b1;
`else
    if_first = 1'b0;
`endif
    c0 = cyc;
    if_req = 1'b1; if_addr = 32'h104;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h200; d_width = 2'd2; d_wdata = 32'hDEADBEEF;
    if (if_first) begin
      push_txn(1'b0, c0, 32'h104, 32'h0, 1'b0, 2'd2, 32'h00000013, 1'b0);
      push_txn(1'b1, c0 + 3, 32'h200, 32'hDEADBEEF, 1'b1, 2'd2, 32'h0, 1'b0);
    end else begin
      push_txn(1'b1, c0, 32'h200, 32'hDEADBEEF, 1'b1, 2'd2, 32'h0, 1'b0);
      push_txn(1'b0, c0 + 3, 32'h104, 32'h0, 1'b0, 2'd2, 32'h00000013, 1'b0);
    end
    tick(); if (if_first) if_req = 1'b0; else d_req = 1'b0;
    tick(); mem_rvalid = 1'b1; mem_rdata = if_first ? 32'h00000013 : 32'h0;
    tick(); mem_rvalid = 1'b0;
    tick(); if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    tick(); mem_rvalid = 1'b1; mem_rdata = if_first ? 32'h0 : 32'h00000013;
    tick(); mem_rvalid = 1'b0;

    // Timeout: no response, fault in 4th WAIT cycle, late response drained.
    c0 = cyc;
    if_req = 1'b1; if_addr = 32'h300; mem_rdata = 32'hFFFFFFFF;
    push_gnt(1'b0, c0);
    push_mem(c0 + 1, 32'h300, 32'h0, 1'b0, 2'd2);
    push_rsp(1'b0, c0 + 5, 32'h0, 1'b1);
    push_txn(1'b1, c0 + 9, 32'h400, 32'h0, 1'b0, 2'd0, 32'h000000AB, 1'b0);
    tick(); if_req = 1'b0;
    tick();
    tick(); d_req = 1'b1; d_we = 1'b0; d_addr = 32'h400; d_width = 2'd0;
    repeat (5) tick();
    mem_rvalid = 1'b1; mem_rdata = 32'h00001234;
    tick(); mem_rvalid = 1'b0;
    tick(); d_req = 1'b0;
    tick(); mem_rvalid = 1'b1; mem_rdata = 32'h000000AB;
    tick(); mem_rvalid = 1'b0;

    // Back-to-back contention with both requesters always requesting.
    c0 = cyc;
    if_req = 1'b1; if_addr = 32'h700;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h600; d_width = 2'd1;
    mem_rvalid = 1'b1;
    for (int i = 0; i < 4; i++) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
      is_d = (i % 2) == 1;
`else
      is_d = 1'b1;
`endif
      rd = 32'hA0000000 + 32'(i);
      mem_rdata = rd;
      push_txn(is_d, c0 + 3 * i, is_d ? 32'h600 : 32'h700, 32'h0, 1'b0,
               is_d ? 2'd1 : 2'd2, rd, 1'b0);
      repeat (3) tick();
    end
    if_req = 1'b0; d_req = 1'b0; mem_rvalid = 1'b0;
    repeat (3) tick();

    n_vec++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d pending events, required 0 (next %s)", sb.size(), sb[0].name);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
